// File: rtl/pipeline_mem_access_pkg.sv
// Shared definitions for the MEM stage: datapath width, load/store funct3
// codes, writeback result-select encodings and the bus FSM states.
package pipeline_mem_access_pkg;

    localparam int unsigned XLEN = 32;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Non-load writeback source
    typedef enum logic [1:0] {
        SEL_ALU    = 2'b00,
        SEL_EXTIMM = 2'b01,
        SEL_PCP4   = 2'b10,
        SEL_PCTGT  = 2'b11
    } result_sel_e;

    // Data-bus handshake FSM
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/pipeline_mem_access_load_align.sv
// Load data alignment: shifts the read word so the addressed byte/half sits
// at bit 0, then sign- or zero-extends according to funct3.
// Ports:
//   i_rdata   in  XLEN  raw read word from the data bus
//   i_offset  in  2     address bits [1:0]
//   i_funct3  in  3     load width/sign
//   o_data    out XLEN  extended load value
module pipeline_mem_access_load_align #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);
    import pipeline_mem_access_pkg::*;

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = i_rdata >> {i_offset, 3'b000};
        o_data  = shifted;
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
            F3_LH:   o_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
            default: o_data = shifted;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_access.sv
// MEM stage of the RV32I 5-stage pipeline. Issues data-memory loads/stores
// over a req/ready bus, stalls upstream while the bus is busy, aborts with a
// bus-error flag after TIMEOUT wait cycles, and registers the writeback
// result into the MEM/WB boundary.
// Ports:
//   i_clk, i_rstn                 clock, async active-low reset
//   i_ctrl_*M, i_alu_resultM, ... EX/MEM register contents
//   o_dmem_req/we/addr/wdata/be   data bus request side
//   i_dmem_ready, i_dmem_rdata    data bus response side
//   o_stall                       combinational freeze of PC/IF/ID/EX and EX/MEM
//   o_*W                          MEM/WB register outputs
module pipeline_mem_access #(
    parameter int unsigned XLEN    = pipeline_mem_access_pkg::XLEN,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_ctrl_reg_wr_enM,
    input  logic            i_ctrl_result_srcM,
    input  logic [1:0]      i_ctrl_mux_selM,
    input  logic            i_ctrl_mem_wr_enM,
    input  logic [3:0]      i_ctrl_mem_byte_selM,
    input  logic [2:0]      i_ctrl_funct3M,
    input  logic [XLEN-1:0] i_alu_resultM,
    input  logic [XLEN-1:0] i_mem_writedataM,
    input  logic [4:0]      i_regfile_rd_addrM,
    input  logic [XLEN-1:0] i_ExtImmM,
    input  logic [XLEN-1:0] i_PCPlus4M,
    input  logic [XLEN-1:0] i_PCTargetM,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_ready,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_stall,
    output logic            o_ctrl_reg_wr_enW,
    output logic [4:0]      o_regfile_rd_addrW,
    output logic [XLEN-1:0] o_resultW,
    output logic            o_misalignW,
    output logic            o_bus_errW
);
    import pipeline_mem_access_pkg::*;

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             mem_op, misalign, illegal, fault, abort, cnt_at_limit;
    logic [1:0]       offset;
    logic [XLEN-1:0]  load_data, result;

    assign offset = i_alu_resultM[1:0];
    assign mem_op = i_ctrl_mem_wr_enM | i_ctrl_result_srcM;

    // Access checks
    always_comb begin
        misalign = ((i_ctrl_funct3M[1:0] == 2'b01) && offset[0]) ||
                   ((i_ctrl_funct3M[1:0] == 2'b10) && (offset != 2'b00));
        if (i_ctrl_mem_wr_enM)
            illegal = !(i_ctrl_funct3M inside {F3_SB, F3_SH, F3_SW});
        else
            illegal = !(i_ctrl_funct3M inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        fault = mem_op & (misalign | illegal);
    end

    // Store alignment; EX/MEM is frozen during WAIT so these stay stable
    assign o_dmem_we    = i_ctrl_mem_wr_enM;
    assign o_dmem_addr  = {i_alu_resultM[XLEN-1:2], 2'b00};
    assign o_dmem_wdata = i_mem_writedataM << {offset, 3'b000};
    assign o_dmem_be    = i_ctrl_mem_byte_selM << offset;

    assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT));

    // Bus FSM: next state and handshake outputs. req/stall are gated by
    // i_rstn so they read 0 throughout reset, not just after the first edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        o_dmem_req = 1'b0;
        o_stall    = 1'b0;
        abort      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_dmem_req = i_rstn & mem_op & ~fault;
                if (o_dmem_req && !i_dmem_ready) begin
                    o_stall = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                o_dmem_req = i_rstn;
                if (i_dmem_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_at_limit) begin
                    abort   = i_rstn;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    o_stall = i_rstn;
                    if (cnt_q != '1)
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    pipeline_mem_access_load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata  (i_dmem_rdata),
        .i_offset (offset),
        .i_funct3 (i_ctrl_funct3M),
        .o_data   (load_data)
    );

    always_comb begin
        result = i_alu_resultM;
        if (i_ctrl_result_srcM) begin
            result = load_data;
        end else begin
            case (result_sel_e'(i_ctrl_mux_selM))
                SEL_ALU:    result = i_alu_resultM;
                SEL_EXTIMM: result = i_ExtImmM;
                SEL_PCP4:   result = i_PCPlus4M;
                SEL_PCTGT:  result = i_PCTargetM;
                default:    result = i_alu_resultM;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled (result/rd hold), capture otherwise
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_ctrl_reg_wr_enW  <= 1'b0;
            o_regfile_rd_addrW <= '0;
            o_resultW          <= '0;
            o_misalignW        <= 1'b0;
            o_bus_errW         <= 1'b0;
        end else if (o_stall) begin
            o_ctrl_reg_wr_enW  <= 1'b0;
            o_misalignW        <= 1'b0;
            o_bus_errW         <= 1'b0;
        end else begin
            o_ctrl_reg_wr_enW  <= i_ctrl_reg_wr_enM & ~fault & ~abort;
            o_regfile_rd_addrW <= i_regfile_rd_addrM;
            o_resultW          <= result;
            o_misalignW        <= fault;
            o_bus_errW         <= abort;
        end
    end

endmodule
